// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data-memory target with fixed wait states.
// One transaction in flight; loads and stores each return one response beat.
// Ports:
//   clk, rst_n (sync, active low)
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_strb : request channel
//   rsp_valid/rsp_ready/rsp_rdata                              : response channel
//   busy : high while a transaction is in WAIT or RESP
// Optional: define MEM_BYTE_STRB_EN to honour req_strb on stores;
//   otherwise stores write the full word and req_strb is ignored.
module data_mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              lat_write;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [STRB_W-1:0] lat_strb;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              commit;
   logic              c_write;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic [STRB_W-1:0] c_strb;
   logic [STRB_W-1:0] c_bytes;

   assign req_ready = (state == S_IDLE) & rst_n;
   assign busy      = (state != S_IDLE);
   assign accept    = req_valid & req_ready;

   // With zero wait states the access commits on the accept edge itself,
   // so the commit path must see the live request rather than the latches.
   always_comb begin
      commit = 1'b0;
      if (rst_n) begin
         if (state == S_IDLE)
            commit = accept && (WAIT_CYCLES == 0);
         else if (state == S_WAIT)
            commit = (cnt == 4'd1);
      end
   end

   always_comb begin
      c_write = lat_write;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
      c_strb  = lat_strb;
      if (state == S_IDLE) begin
         c_write = req_write;
         c_addr  = req_addr;
         c_wdata = req_wdata;
         c_strb  = req_strb;
      end
   end

`ifdef MEM_BYTE_STRB_EN
   assign c_bytes = c_strb;
`else
   logic unused_strb;
   assign unused_strb = ^c_strb;
   assign c_bytes     = '1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_strb  <= req_strb;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (commit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= c_write ? '0 : mem[c_addr];
         end
      end
   end

   // Array is never reset; commit already excludes reset edges, so a
   // store caught by reset leaves the contents untouched.
   always_ff @(posedge clk) begin
      if (commit && c_write) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (c_bytes[i])
               mem[c_addr][i*8 +: 8] <= c_wdata[i*8 +: 8];
         end
      end
   end

endmodule
